// File: rtl/vga_pixel_pipe.sv
// VGA raster engine: sync timing, scaled 1bpp framebuffer fetch, resynchronised fg/bg colour to RGB.
// Latency RAM_LAT+2 clocks from counter to pins (colour selects: 3 clocks); free-running, no backpressure.
module vga_pixel_pipe #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int COLOR_BITS = 2,
    parameter int X_SCALE    = 1,
    parameter int Y_SCALE    = 2,
    parameter int FB_STRIDE  = 800,
    parameter int ADDR_W     = 18,
    parameter int RAM_LAT    = 1
) (
    input  logic                  vgaclk,
    input  logic                  vgarst_n,
    output logic [ADDR_W-1:0]     raddr,
    input  logic                  bit_from_ram,
    input  logic [2:0]            fg_rgb,
    input  logic [2:0]            bg_rgb,
    output logic [COLOR_BITS-1:0] vr,
    output logic [COLOR_BITS-1:0] vg,
    output logic [COLOR_BITS-1:0] vb,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic                  frame_start,
    output logic                  line_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DLY     = RAM_LAT + 1;

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] X_DIV    = HW'(X_SCALE);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] Y_DIV    = VW'(Y_SCALE);
    localparam logic          POL      = (SYNC_POL != 0);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic fs;
        logic ls;
    } ctl_t;

    logic [HW-1:0]         hcnt_q, hcnt_d;
    logic [VW-1:0]         vcnt_q, vcnt_d;
    logic [ADDR_W-1:0]     raddr_q, raddr_d;
    ctl_t                  dly_q [DLY];
    ctl_t                  dly_d [DLY];
    logic [2:0]            fg_s1_q, fg_s1_d, fg_s2_q, fg_s2_d;
    logic [2:0]            bg_s1_q, bg_s1_d, bg_s2_q, bg_s2_d;
    logic [COLOR_BITS-1:0] vr_q, vr_d, vg_q, vg_d, vb_q, vb_d;
    logic                  hsync_q, hsync_d, vsync_q, vsync_d;
    logic                  de_q, de_d, fs_q, fs_d, ls_q, ls_d;
    logic [2:0]            fg_eff, bg_eff, sel;
    logic                  active0;
    ctl_t                  ctl_out;

    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
    end

    // Stage 0: decode the raster position and launch the framebuffer read.
    always_comb begin
        active0   = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
        dly_d[0]  = '{act: active0,
                      hs:  (hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST),
                      vs:  (vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST),
                      fs:  (hcnt_q == '0) && (vcnt_q == '0),
                      ls:  (hcnt_q == '0) && (vcnt_q < V_ACT_C)};
        for (int i = 1; i < DLY; i++) begin
            dly_d[i] = dly_q[i-1];
        end
        raddr_d = raddr_q;
        if (active0) begin
            raddr_d = ADDR_W'(32'(vcnt_q / Y_DIV) * 32'(FB_STRIDE) + 32'(hcnt_q / X_DIV));
        end
    end

    // Identical selects would render invisibly, so force white-on-black instead.
    always_comb begin
        fg_s1_d = fg_rgb;
        bg_s1_d = bg_rgb;
        fg_s2_d = fg_s1_q;
        bg_s2_d = bg_s1_q;
        fg_eff  = fg_s2_q;
        bg_eff  = bg_s2_q;
        if (fg_s2_q == bg_s2_q) begin
            fg_eff = 3'b111;
            bg_eff = 3'b000;
        end
        sel     = bit_from_ram ? fg_eff : bg_eff;
        ctl_out = dly_q[DLY-1];
        vr_d    = ctl_out.act ? {COLOR_BITS{sel[0]}} : '0;
        vg_d    = ctl_out.act ? {COLOR_BITS{sel[1]}} : '0;
        vb_d    = ctl_out.act ? {COLOR_BITS{sel[2]}} : '0;
        hsync_d = ctl_out.hs ? POL : ~POL;
        vsync_d = ctl_out.vs ? POL : ~POL;
        de_d    = ctl_out.act;
        fs_d    = ctl_out.fs;
        ls_d    = ctl_out.ls;
    end

    always_ff @(posedge vgaclk) begin
        if (!vgarst_n) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            raddr_q <= '0;
            for (int i = 0; i < DLY; i++) begin
                dly_q[i] <= '0;
            end
            fg_s1_q <= '0;
            fg_s2_q <= '0;
            bg_s1_q <= '0;
            bg_s2_q <= '0;
            vr_q    <= '0;
            vg_q    <= '0;
            vb_q    <= '0;
            hsync_q <= ~POL;
            vsync_q <= ~POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            raddr_q <= raddr_d;
            for (int i = 0; i < DLY; i++) begin
                dly_q[i] <= dly_d[i];
            end
            fg_s1_q <= fg_s1_d;
            fg_s2_q <= fg_s2_d;
            bg_s1_q <= bg_s1_d;
            bg_s2_q <= bg_s2_d;
            vr_q    <= vr_d;
            vg_q    <= vg_d;
            vb_q    <= vb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
        end
    end

    assign raddr       = raddr_q;
    assign vr          = vr_q;
    assign vg          = vg_q;
    assign vb          = vb_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Two raster configurations run side by side against a position/arithmetic model of the raster.
module tb_vga_pixel_pipe;
    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, pol, cb, xs, ys, stride, aw, lat;
    } cfg_t;

    typedef struct packed {
        logic [17:0] raddr;
        logic [3:0]  r, g, b;
        logic        hs, vs, de, fs, ls;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  fg_rgb = 3'b000;
    logic [2:0]  bg_rgb = 3'b000;

    logic [17:0] raddr_a;
    logic        bit_a;
    logic [1:0]  vr_a, vg_a, vb_a;
    logic        hsync_a, vsync_a, de_a, fs_a, ls_a;
    logic [6:0]  raddr_b;
    logic        bit_b;
    logic [3:0]  vr_b, vg_b, vb_b;
    logic        hsync_b, vsync_b, de_b, fs_b, ls_b;
    logic        ram_a = 1'b0;
    logic [2:0]  ram_b = 3'b000;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sn = 0;

    always #5 clk = ~clk;

    vga_pixel_pipe #(
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut_a (
        .vgaclk(clk), .vgarst_n(rst_n), .raddr(raddr_a), .bit_from_ram(bit_a),
        .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .vr(vr_a), .vg(vg_a), .vb(vb_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .frame_start(fs_a), .line_start(ls_a)
    );

    vga_pixel_pipe #(
        .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1), .COLOR_BITS(4), .X_SCALE(2), .Y_SCALE(1),
        .FB_STRIDE(40), .ADDR_W(7), .RAM_LAT(3)
    ) dut_b (
        .vgaclk(clk), .vgarst_n(rst_n), .raddr(raddr_b), .bit_from_ram(bit_b),
        .fg_rgb(fg_rgb), .bg_rgb(bg_rgb), .vr(vr_b), .vg(vg_b), .vb(vb_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .frame_start(fs_b), .line_start(ls_b)
    );

    // Framebuffer contents: one bit per address.
    function automatic logic membit(input int a);
        return a[0] ^ a[3];
    endfunction

    always @(posedge clk) begin
        ram_a <= membit(int'(raddr_a));
        ram_b <= {ram_b[1:0], membit(int'(raddr_b))};
    end
    assign bit_a = ram_a;
    assign bit_b = ram_b[2];

    function automatic int htot(input cfg_t c);
        return c.ha + c.hf + c.hs + c.hb;
    endfunction

    function automatic int vtot(input cfg_t c);
        return c.va + c.vf + c.vs + c.vb;
    endfunction

    function automatic bit is_act(input cfg_t c, input int q);
        return (q % htot(c)) < c.ha && ((q / htot(c)) % vtot(c)) < c.va;
    endfunction

    function automatic int addr_of(input cfg_t c, input int q);
        int h, v;
        h = q % htot(c);
        v = (q / htot(c)) % vtot(c);
        return ((v / c.ys) * c.stride + h / c.xs) % (1 << c.aw);
    endfunction

    function automatic logic [17:0] next_ra(input cfg_t c, input int n, input logic [17:0] ra);
        if (n == 0) return '0;
        if (is_act(c, n - 1)) return 18'(addr_of(c, n - 1));
        return ra;
    endfunction

    // Expected pins at clock n after reset: raster position n-(RAM_LAT+2) drives them.
    function automatic obs_t model(input cfg_t c, input int n, input logic [5:0] col, input logic [17:0] ra);
        obs_t o;
        int q, h, v;
        logic idle;
        logic [2:0] fg, bg, sel;
        logic [3:0] m;
        idle    = (c.pol == 0);
        o       = '0;
        o.raddr = ra;
        o.hs    = idle;
        o.vs    = idle;
        if (n >= c.lat + 2) begin
            q    = n - c.lat - 2;
            h    = q % htot(c);
            v    = (q / htot(c)) % vtot(c);
            o.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? !idle : idle;
            o.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? !idle : idle;
            o.de = is_act(c, q);
            o.fs = (h == 0 && v == 0);
            o.ls = (h == 0 && v < c.va);
            if (o.de) begin
                fg = col[5:3];
                bg = col[2:0];
                if (fg == bg) begin
                    fg = 3'b111;
                    bg = 3'b000;
                end
                sel = membit(addr_of(c, q)) ? fg : bg;
                m   = 4'((1 << c.cb) - 1);
                o.r = sel[0] ? m : 4'd0;
                o.g = sel[1] ? m : 4'd0;
                o.b = sel[2] ? m : 4'd0;
            end
        end
        return o;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    initial begin
        cfg_t ca, cb;
        obs_t ea, eb, ga, gb;
        logic [17:0] ra_a, ra_b;
        logic [5:0] h0, h1, h2;
        int nres, hlow, vlow;
        bit first_seg;
        ca = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 8, vf: 1, vs: 2, vb: 2, pol: 0,
               cb: 2, xs: 1, ys: 2, stride: 800, aw: 18, lat: 1};
        cb = '{ha: 12, hf: 2, hs: 3, hb: 3, va: 5, vf: 1, vs: 1, vb: 1, pol: 1,
               cb: 4, xs: 2, ys: 1, stride: 40, aw: 7, lat: 3};
        ra_a = '0; ra_b = '0; h0 = '0; h1 = '0; h2 = '0;
        nres = 0; hlow = 0; vlow = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cyc = 0;
                nres++;
                hlow = 0;
                vlow = 0;
            end else begin
                cyc++;
            end
            first_seg = (nres < 4);
            h2 = h1; h1 = h0; h0 = {fg_rgb, bg_rgb};
            ra_a = next_ra(ca, cyc, ra_a);
            ra_b = next_ra(cb, cyc, ra_b);
            ea = model(ca, cyc, h2, ra_a);
            eb = model(cb, cyc, h2, ra_b);
            ga = '{raddr: raddr_a, r: {2'b00, vr_a}, g: {2'b00, vg_a}, b: {2'b00, vb_a},
                   hs: hsync_a, vs: vsync_a, de: de_a, fs: fs_a, ls: ls_a};
            gb = '{raddr: {11'd0, raddr_b}, r: vr_b, g: vg_b, b: vb_b,
                   hs: hsync_b, vs: vsync_b, de: de_b, fs: fs_b, ls: ls_b};
            check("pipe_a", 64'(ga), 64'(ea));
            check("pipe_b", 64'(gb), 64'(eb));

            if (cyc >= 3 && cyc < 803 && !hsync_a) hlow++;
            if (cyc >= 3 && cyc < 10403 && !vsync_a) vlow++;
            if (cyc == 0) begin
                check("rst_a", 64'({raddr_a, de_a, hsync_a, vsync_a, vr_a, vg_a, vb_a, fs_a, ls_a}),
                      64'({18'd0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0}));
                check("rst_b", 64'({raddr_b, de_b, hsync_b, vsync_b, vr_b, fs_b}),
                      64'({7'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}));
            end
            if (cyc == 2) check("fs_a_early", 64'(fs_a), 64'd0);
            if (cyc == 3) check("fs_a_at_L", 64'(fs_a), 64'd1);
            if (cyc == 5) check("fs_b_at_L", 64'(fs_b), 64'd1);
            if (cyc == 6) check("raddr_b_x5", 64'(raddr_b), 64'd2);
            if (cyc == 92) check("raddr_b_trunc", 64'(raddr_b), 64'd37);
            if (cyc == 18) check("hs_b_pre", 64'(hsync_b), 64'd0);
            if (cyc == 19) check("hs_b_on", 64'(hsync_b), 64'd1);
            if (first_seg) begin
                if (cyc == 7) check("fg_b_pix", 64'({vr_b, de_b}), 64'({4'hF, 1'b1}));
                if (cyc == 10) check("bg_b_pix", 64'({vr_b, de_b}), 64'({4'h0, 1'b1}));
                if (cyc == 658) check("hs_a_pre", 64'(hsync_a), 64'd1);
                if (cyc == 659) check("hs_a_fall", 64'(hsync_a), 64'd0);
                if (cyc == 803) check("hs_a_width", 64'(hlow), 64'd96);
                if (cyc == 10403) check("vs_a_width", 64'(vlow), 64'd1600);
                if (cyc == 5611) check("raddr_a_10_7", 64'(raddr_a), 64'd2410);
                if (cyc == 6240) check("raddr_a_last", 64'(raddr_a), 64'd3039);
                if (cyc == 6340) check("raddr_a_hold", 64'(raddr_a), 64'd3039);
                if (cyc == 4813) check("eq_fg", 64'({vr_a, vg_a, vb_a, de_a}), 64'({6'b111111, 1'b1}));
                if (cyc == 4814) check("eq_bg", 64'({vr_a, vg_a, vb_a, de_a}), 64'({6'b000000, 1'b1}));
                if (cyc == 5613) check("red_fg", 64'({vr_a, vg_a, vb_a, de_a}), 64'({6'b110000, 1'b1}));
                if (cyc == 5614) check("blue_bg", 64'({vr_a, vg_a, vb_a, de_a}), 64'({6'b000011, 1'b1}));
            end
        end
    end

    // Make the next assignments first visible at clock edge k after reset.
    task automatic goto(input int k);
        while (sn < k) begin
            @(negedge clk);
            sn++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sn = 1;
        goto(200);
        fg_rgb = 3'b110; bg_rgb = 3'b011;
        goto(4500);
        fg_rgb = 3'b010; bg_rgb = 3'b010;
        goto(5000);
        fg_rgb = 3'b001; bg_rgb = 3'b100;
        goto(10600);
        while (sn < 25000) begin
            goto(sn + 37);
            fg_rgb = 3'($urandom_range(0, 7));
            bg_rgb = ($urandom_range(0, 3) == 0) ? fg_rgb : 3'($urandom_range(0, 7));
        end
        goto(25101);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sn = 1;
        goto(3500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_pixel_pipe.md
# vga_pixel_pipe

Parametrised VGA raster engine: generates sync timing, fetches one bit per pixel from the dual-port framebuffer RAM with configurable read latency and pixel scaling, and drives RGB from resynchronised foreground/background colour selects. Sits between the framebuffer read port and the VGA DAC pins. It is the generalised successor of the fixed 640x480, 2-bit, Y-doubled output stage. It adds parametrised timing, colour depth, X/Y scaling, RAM latency, sync polarity and frame/line strobes, with all outputs latency-aligned.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width (clocks)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- COLOR_BITS, 2, bits per colour channel; 1-bit selects replicated across all bits
- X_SCALE / Y_SCALE, 1 / 2, integer pixel replication factors (≥1)
- FB_STRIDE, 800, framebuffer words per source line
- ADDR_W, 18, framebuffer address width
- RAM_LAT, 1, clocks from raddr change to valid bit_from_ram (≥1)

Ports:
- vgaclk  in  1  pixel clock
- vgarst_n  in  1  synchronous active-low reset (one clock; reset is synchronous, active-low)
- raddr  out  ADDR_W  framebuffer read address
- bit_from_ram  in  1  pixel bit, valid RAM_LAT clocks after raddr
- fg_rgb  in  3  foreground select {b,g,r}, asynchronous to vgaclk
- bg_rgb  in  3  background select {b,g,r}, asynchronous to vgaclk
- vr / vg / vb  out  COLOR_BITS each  DAC drive
- hsync / vsync  out  1  sync, level per SYNC_POL
- de  out  1  data enable, aligned with RGB
- frame_start  out  1  one-clock pulse aligned with the first visible pixel of a frame
- line_start  out  1  one-clock pulse aligned with the first visible pixel of each visible line

## Operation
- Counters: hcnt 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP); vcnt increments when hcnt wraps, 0..V_TOTAL-1, wraps to 0. Width is $clog2 of the total.
- Stage 0 active: hcnt<H_ACTIVE && vcnt<V_ACTIVE. hsync_raw is asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync_raw uses the same form on vcnt.
- Address: when active, raddr <= ((vcnt/Y_SCALE)*FB_STRIDE + hcnt/X_SCALE) mod 2^ADDR_W. During blanking, raddr holds its last value.
- Colour sync: fg_rgb/bg_rgb pass through 2-flop synchronisers.
- Equal-colour override: if the synced fg == synced bg, the effective fg = 3'b111 and the effective bg = 3'b000. The override is evaluated every clock.
- Pixel: when delayed-active, each channel = {COLOR_BITS{sel}}, where sel is the fg bit if bit_from_ram=1, else the bg bit. Otherwise all RGB = 0.
- hsync, vsync, de, frame_start and line_start are stage-0 signals delayed to align exactly with RGB. frame_start source: hcnt==0 && vcnt==0. line_start source: hcnt==0 && vcnt<V_ACTIVE.
- Mid-frame change of fg/bg takes effect at any pixel; no frame-boundary latching.

## Timing
- Pipeline: counters (t) -> raddr registered (t+1) -> bit valid (t+1+RAM_LAT) -> RGB/sync/de registered (t+2+RAM_LAT). Total latency L = RAM_LAT+2; default L = 3.
- Colour-select latency: 2 sync flops plus 1 output register = 3 clocks from input change to RGB.
- Reset (vgarst_n=0 at a clock edge): hcnt=vcnt=0. raddr=0; RGB=0; de=0; frame_start=line_start=0. hsync and vsync are driven inactive (=~SYNC_POL); synchroniser flops and delay-line stages are cleared.
  - After reset deasserts, stage 0 restarts at (0,0). frame_start fires L clocks after the first clock with vgarst_n=1.
  - Reset asserted mid-frame aborts the frame immediately; no partial flush.
- Synchroniser reset to 0 means fg==bg, so the output is white-on-black until real selects propagate.
- Boundaries: last visible pixel (H_ACTIVE-1, V_ACTIVE-1) is followed by blanking with RGB=0 exactly L clocks later.
  - hcnt and vcnt wrap on the same clock at (H_TOTAL-1, V_TOTAL-1).
  - Address overflow beyond 2^ADDR_W truncates silently.

## Test plan
- Reset then free-run, defaults: hsync low for exactly 96 clocks per 800-clock line. First hsync falling edge is at clock 656+3 after reset release. vsync low for 2 lines (1600 clocks) per 525-line frame.
- Counter (x=10, y=7) -> raddr=2410 one clock later. Counter (639,479) -> raddr=191839. raddr holds 191839 through blanking.
- fg_rgb=3'b001, bg_rgb=3'b100; drive bit_from_ram=1 for a pixel -> 3 clocks after its counter: vr=2'b11, vg=00, vb=00, de=1. With bit_from_ram=0 -> vb=11, others 00.
- fg_rgb=bg_rgb=3'b010 -> after 3 clocks, bit=1 gives all channels 11 and bit=0 gives all channels 00.
- RAM_LAT=3, X_SCALE=2, COLOR_BITS=4: counter x=5,y=0 -> raddr=2; RGB appears 5 clocks after the counter; an fg pixel yields vr=4'b1111; de and sync stay aligned.
- Assert vgarst_n=0 at (300,200) for one clock -> next clock all outputs at reset values. Frame restarts and frame_start pulses L clocks after release.
